multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_read_port.sv | 72 +++++++
 rtl/multiport_register_file.sv | 158 +++++++++++++++
 tb/tb_multiport_register_file.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multiport register file:
//   - default parameter values (DATA_W, DEPTH, NUM_RD)
//   - clear-sweep FSM state encoding
//   - small helper for in-range index checks
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_RD = 2;

    // Clear-sweep controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    // True when idx addresses an existing entry. The index is widened by
    // one bit so a depth of 2**N can be compared without overflow.
    function automatic logic idx_in_range(input logic [8:0] idx_ext, input logic [8:0] depth);
        return (idx_ext < depth);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One registered read port of the register file. Selects the addressed entry
// (zero when the entry is invalid or the index is out of range), optionally
// replaced by forwarded write data, and registers it when read_en is high.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   read_en       : read request, sampled on the rising edge
//   read_addr     : entry index to read
//   mem_flat      : all entries, entry i at [i*DATA_W +: DATA_W]
//   entry_valid   : per-entry written flag
//   bypass_hit    : forward bypass_data instead of the stored entry
//   bypass_data   : data being written this cycle
//   read_out      : registered read data (holds while read_en is low)
//   read_valid    : one-cycle qualifier per accepted request
// -----------------------------------------------------------------------------
module regfile_read_port #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read_en,
    input  logic [ADDR_W-1:0]       read_addr,
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    input  logic [DEPTH-1:0]        entry_valid,
    input  logic                    bypass_hit,
    input  logic [DATA_W-1:0]       bypass_data,
    output logic [DATA_W-1:0]       read_out,
    output logic                    read_valid
);

    logic [DATA_W-1:0] sel_data_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] read_out_r;
    logic              read_valid_r;

    // AND-OR mux over all entries; out-of-range indices match nothing and
    // invalid entries are masked, so both read back as zero.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            sel_data_s = sel_data_s |
                (mem_flat[i*DATA_W +: DATA_W] &
                 {DATA_W{(read_addr == ADDR_W'(i)) && entry_valid[i]}});
        end
        if (bypass_hit) begin
            rd_data_s = bypass_data;
        end else begin
            rd_data_s = sel_data_s;
        end
    end

    // Read data register: updates only on a request, qualifier pulses per request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_out_r   <= {DATA_W{1'b0}};
            read_valid_r <= 1'b0;
        end else begin
            read_valid_r <= read_en;
            if (read_en) begin
                read_out_r <= rd_data_s;
            end
        end
    end

    assign read_out   = read_out_r;
    assign read_valid = read_valid_r;

endmodule

// File: rtl/multiport_register_file.sv
// -----------------------------------------------------------------------------
// multiport_register_file
// Register file with one write port, NUM_RD registered read ports (1-cycle
// latency) and a background clear sweep that zeroes one entry per cycle.
//
// Configuration macro:
//   REGFILE_WRITE_BYPASS_EN  defined   -> write-first: a same-cycle read of an
//                                         entry being written returns data_in
//                            undefined -> read-first: returns old content
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   write_en     : write request (dropped while busy or out of range)
//   write_addr   : write index
//   data_in      : write data
//   read_en      : per-port read request
//   read_addr    : packed read indices, port p at [p*ADDR_W +: ADDR_W]
//   read_out     : packed registered read data, port p at [p*DATA_W +: DATA_W]
//   read_valid   : per-port read-data qualifier
//   clear_req    : start a full clear sweep (ignored while one runs)
//   busy         : high while the clear sweep runs
//   entry_valid  : per-entry written-since-clear flag
// -----------------------------------------------------------------------------
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_RD-1:0]        read_en,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_out,
    output logic [NUM_RD-1:0]        read_valid,
    input  logic                     clear_req,
    output logic                     busy,
    output logic [DEPTH-1:0]         entry_valid
);

    localparam logic [8:0] DEPTH_EXT = 9'(DEPTH);

    clear_state_t          state_r;
    clear_state_t          state_next_s;
    logic [ADDR_W-1:0]     clr_cnt_r;
    logic [ADDR_W-1:0]     clr_cnt_next_s;
    logic                  busy_r;
    logic                  clear_active_s;
    logic                  clr_last_s;

    logic [DATA_W-1:0]       mem_r [DEPTH];
    logic [DEPTH-1:0]        entry_valid_r;
    logic [DEPTH*DATA_W-1:0] mem_flat_s;
    logic                    wr_accept_s;
    logic [NUM_RD-1:0]       bypass_hit_s;

    assign clear_active_s = (state_r == CLEAR);
    assign clr_last_s     = (clr_cnt_r == ADDR_W'(DEPTH - 1));
    assign wr_accept_s    = write_en && !clear_active_s &&
                            idx_in_range(9'(write_addr), DEPTH_EXT);

    // Clear-sweep next state and counter; clear_req is only honoured in IDLE
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        case (state_r)
            IDLE: begin
                if (clear_req) begin
                    state_next_s   = CLEAR;
                    clr_cnt_next_s = {ADDR_W{1'b0}};
                end else begin
                    state_next_s   = IDLE;
                end
            end
            CLEAR: begin
                if (clr_last_s) begin
                    state_next_s   = IDLE;
                    clr_cnt_next_s = {ADDR_W{1'b0}};
                end else begin
                    clr_cnt_next_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_next_s   = IDLE;
                clr_cnt_next_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Clear-sweep state, counter and registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            clr_cnt_r <= {ADDR_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            busy_r    <= (state_next_s == CLEAR);
        end
    end

    // Storage array: sweep clears one entry per cycle, writes blocked meanwhile
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            entry_valid_r <= {DEPTH{1'b0}};
        end else if (clear_active_s) begin
            mem_r[clr_cnt_r]         <= {DATA_W{1'b0}};
            entry_valid_r[clr_cnt_r] <= 1'b0;
        end else if (wr_accept_s) begin
            mem_r[write_addr]         <= data_in;
            entry_valid_r[write_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign mem_flat_s[i*DATA_W +: DATA_W] = mem_r[i];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
`ifdef REGFILE_WRITE_BYPASS_EN
        // Write-first: forward data_in when this port reads the entry being written
        assign bypass_hit_s[p] = wr_accept_s &&
                                 (read_addr[p*ADDR_W +: ADDR_W] == write_addr);
`else
        assign bypass_hit_s[p] = 1'b0;
`endif

        regfile_read_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_read_port (
            .clk         (clk),
            .rst         (rst),
            .read_en     (read_en[p]),
            .read_addr   (read_addr[p*ADDR_W +: ADDR_W]),
            .mem_flat    (mem_flat_s),
            .entry_valid (entry_valid_r),
            .bypass_hit  (bypass_hit_s[p]),
            .bypass_data (data_in),
            .read_out    (read_out[p*DATA_W +: DATA_W]),
            .read_valid  (read_valid[p])
        );
    end

    assign busy        = busy_r;
    assign entry_valid = entry_valid_r;

endmodule

// File: tb/tb_multiport_register_file.sv
// -----------------------------------------------------------------------------
// tb_multiport_register_file
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural array model. A second instance with DEPTH=6 exercises
// out-of-range indices.
// -----------------------------------------------------------------------------
module tb_multiport_register_file;

    localparam int DW = 12;
    localparam int DP = 8;
    localparam int NR = 2;
    localparam int AW = 3;
`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           write_en;
    logic [AW-1:0]  write_addr;
    logic [DW-1:0]  data_in;
    logic [NR-1:0]  read_en;
    logic [NR*AW-1:0] read_addr;
    logic [NR*DW-1:0] read_out;
    logic [NR-1:0]  read_valid;
    logic           clear_req;
    logic           busy;
    logic [DP-1:0]  entry_valid;

    logic           w6_en;
    logic [2:0]     w6_addr;
    logic [DW-1:0]  d6_in;
    logic [1:0]     r6_en;
    logic [5:0]     r6_addr;
    logic [23:0]    r6_out;
    logic [1:0]     r6_valid;
    logic           c6_req;
    logic           busy6;
    logic [5:0]     ev6;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    // behavioural model
    logic [DW-1:0] m_mem [DP];
    logic [DP-1:0] m_valid;
    logic [DW-1:0] m_out [NR];
    logic [NR-1:0] m_rv;
    int            sweep_left;
    int            sweep_idx;

    multiport_register_file #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) u_dut (
        .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
        .data_in(data_in), .read_en(read_en), .read_addr(read_addr),
        .read_out(read_out), .read_valid(read_valid), .clear_req(clear_req),
        .busy(busy), .entry_valid(entry_valid)
    );

    multiport_register_file #(.DATA_W(DW), .DEPTH(6), .NUM_RD(2)) u_dut6 (
        .clk(clk), .rst(rst), .write_en(w6_en), .write_addr(w6_addr),
        .data_in(d6_in), .read_en(r6_en), .read_addr(r6_addr),
        .read_out(r6_out), .read_valid(r6_valid), .clear_req(c6_req),
        .busy(busy6), .entry_valid(ev6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_cnt++;
        if (got !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
        for (int p = 0; p < NR; p++) m_out[p] = '0;
        m_valid    = '0;
        m_rv       = '0;
        sweep_left = 0;
        sweep_idx  = 0;
    endtask

    // One clock of traffic: drive, predict, clock, compare everything
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                        input logic [NR-1:0] re, input logic [NR*AW-1:0] ra, input logic cr);
        logic          acc;
        logic [AW-1:0] a;
        write_en   = we;
        write_addr = wa;
        data_in    = d;
        read_en    = re;
        read_addr  = ra;
        clear_req  = cr;
        acc = we && (sweep_left == 0);
        for (int p = 0; p < NR; p++) begin
            m_rv[p] = re[p];
            if (re[p]) begin
                a = ra[p*AW +: AW];
                if (BYPASS && acc && (a == wa)) m_out[p] = d;
                else m_out[p] = m_valid[a] ? m_mem[a] : '0;
            end
        end
        @(posedge clk);
        if (sweep_left > 0) begin
            m_mem[sweep_idx]   = '0;
            m_valid[sweep_idx] = 1'b0;
            sweep_idx++;
            sweep_left--;
        end else begin
            if (acc) begin
                m_mem[wa]   = d;
                m_valid[wa] = 1'b1;
            end
            if (cr) begin
                sweep_left = DP;
                sweep_idx  = 0;
            end
        end
        #1;
        for (int p = 0; p < NR; p++) begin
            check($sformatf("read_out[%0d]", p), 32'(read_out[p*DW +: DW]), 32'(m_out[p]));
        end
        check("read_valid", 32'(read_valid), 32'(m_rv));
        check("busy", 32'(busy), 32'(sweep_left > 0));
        check("entry_valid", 32'(entry_valid), 32'(m_valid));
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        rst = 1'b1;
        write_en = 1'b0; write_addr = '0; data_in = '0; read_en = '0; read_addr = '0; clear_req = 1'b0;
        w6_en = 1'b0; w6_addr = '0; d6_in = '0; r6_en = '0; r6_addr = '0; c6_req = 1'b0;
        model_reset();
        #12;
        check("rst_read_out", 32'(read_out), 32'h0);
        check("rst_read_valid", 32'(read_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_entry_valid", 32'(entry_valid), 32'h0);
        rst = 1'b0;

        // DEPTH=6 instance: out-of-range write dropped, out-of-range read is zero
        w6_en = 1'b1; w6_addr = 3'd7; d6_in = 12'hFFF;
        @(posedge clk); #1;
        check("d6_oob_write_ev", 32'(ev6), 32'h0);
        w6_addr = 3'd3; d6_in = 12'h3C3;
        @(posedge clk); #1;
        check("d6_write_ev", 32'(ev6), 32'h08);
        w6_en = 1'b0; r6_en = 2'b11; r6_addr = {3'd6, 3'd7};
        @(posedge clk); #1;
        check("d6_oob_read", 32'(r6_out), 32'h0);
        check("d6_oob_valid", 32'(r6_valid), 32'h3);
        r6_addr = {3'd3, 3'd7};
        @(posedge clk); #1;
        check("d6_read_p1", 32'(r6_out[23:12]), 32'h3C3);
        check("d6_read_p0", 32'(r6_out[11:0]), 32'h0);
        r6_en = 2'b00;

        // basic write then read
        step(1'b1, 3'd5, 12'hABC, 2'b00, '0, 1'b0);
        step(1'b0, 3'd0, 12'h0, 2'b01, {3'd0, 3'd5}, 1'b0);
        check("basic_data", 32'(read_out[11:0]), 32'hABC);
        check("basic_valid0", 32'(read_valid[0]), 32'h1);
        check("basic_ev", 32'(entry_valid), 32'h20);
        step(1'b0, 3'd0, 12'h0, 2'b10, {3'd3, 3'd0}, 1'b0);
        check("unwritten_read", 32'(read_out[23:12]), 32'h0);
        check("unwritten_valid", 32'(read_valid), 32'h2);
        idle();
        check("hold_data", 32'(read_out[11:0]), 32'hABC);
        step(1'b0, 3'd0, 12'h0, 2'b11, {3'd5, 3'd5}, 1'b0);
        check("same_entry", 32'(read_out), 32'hABCABC);

        // same-cycle write and read of the same entry
        step(1'b1, 3'd2, 12'h456, 2'b00, '0, 1'b0);
        step(1'b1, 3'd2, 12'h123, 2'b01, {3'd0, 3'd2}, 1'b0);
        check("bypass_data", 32'(read_out[11:0]), BYPASS ? 32'h123 : 32'h456);
        step(1'b0, 3'd0, 12'h0, 2'b01, {3'd0, 3'd2}, 1'b0);
        check("after_write", 32'(read_out[11:0]), 32'h123);

        // full clear sweep
        for (int i = 0; i < DP; i++) step(1'b1, AW'(i), DW'($urandom), 2'b00, '0, 1'b0);
        check("filled_ev", 32'(entry_valid), 32'hFF);
        step(1'b0, '0, '0, 2'b00, '0, 1'b1);
        busy_cycles = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            busy_cycles++;
            step(1'b1, 3'd1, 12'h777, 2'b11, NR*AW'($urandom), (k == 2));
        end
        check("sweep_len", 32'(busy_cycles), 32'd8);
        check("sweep_ev", 32'(entry_valid), 32'h0);
        for (int i = 0; i < DP; i++) begin
            step(1'b0, '0, '0, 2'b11, {AW'(i), AW'(i)}, 1'b0);
            check("post_clear_read", 32'(read_out), 32'h0);
        end

        // write accepted alongside clear_req, then erased
        step(1'b1, 3'd6, 12'h321, 2'b00, '0, 1'b1);
        check("wr_with_clear_ev", 32'(entry_valid[6]), 32'h1);
        for (int k = 0; k < 20 && busy; k++) idle();
        check("wr_with_clear_erased", 32'(entry_valid), 32'h0);

        // asynchronous reset mid-sweep
        step(1'b1, 3'd7, 12'h9E1, 2'b00, '0, 1'b0);
        step(1'b0, '0, '0, 2'b00, '0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 2'b11, {3'd7, 3'd7}, 1'b0);
        check("pre_rst_data", 32'(read_out[11:0]), 32'h9E1);
        #2 rst = 1'b1;
        #1;
        check("arst_read_out", 32'(read_out), 32'h0);
        check("arst_read_valid", 32'(read_valid), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ev", 32'(entry_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        step(1'b1, 3'd4, 12'h5A5, 2'b00, '0, 1'b0);
        check("post_rst_write", 32'(entry_valid), 32'h10);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom), AW'($urandom), DW'($urandom), NR'($urandom),
                 (NR*AW)'($urandom), ($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
